// File: rtl/fb_arb_pkg.sv
// Shared constants and types for the overlay framebuffer arbiter.
//   FB_DEPTH / FB_ADDR_W : default framebuffer geometry (640x480, 1 bit per pixel)
//   SLOT_DISP            : slot phase reserved for the VGA scan read
//   SLOT_RD_CAPTURE      : phase whose closing edge loads disp_data (RAM data is
//                          valid one cycle after the display address)
//   clr_state_e          : clear sequencer state encoding
//   OOB_CNT_W            : width of the saturating dropped-write counter
package fb_arb_pkg;
  localparam int         FB_DEPTH        = 307200;
  localparam int         FB_ADDR_W       = 19;
  localparam int         OOB_CNT_W       = 8;
  localparam logic [1:0] SLOT_DISP       = 2'd0;
  localparam logic [1:0] SLOT_RD_CAPTURE = 2'd1;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;
endpackage

// File: rtl/fb_clear_seq.sv
// Clear-screen sequencer: sweeps addresses 0..DEPTH-1, one per write slot.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   start_i : request a clear (ignored unless idle)
//   step_i  : a write slot is available this cycle
//   busy_o  : sweep in progress (owns every write slot)
//   done_o  : one-cycle pulse after the last address is written
//   addr_o  : address to clear this cycle
module fb_clear_seq
  import fb_arb_pkg::*;
#(
  parameter int DEPTH          = FB_DEPTH,
  parameter int ADDR_WIDTH     = FB_ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  step_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] addr_o
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  // Resetting straight into CLEAR makes the first post-reset cycle part of
  // the sweep; phase is 0 throughout reset, so no write escapes meanwhile.
  localparam clr_state_e RST_STATE = CLEAR_ON_RESET ? CLR_CLEAR : CLR_IDLE;

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  last;

  assign last = (addr_q == LAST_ADDR);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RST_STATE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      CLR_IDLE:  if (start_i) state_d = CLR_CLEAR;
      CLR_CLEAR: if (step_i) begin
        addr_d = last ? '0 : addr_q + 1'b1;
        if (last) state_d = CLR_DONE;
      end
      CLR_DONE:  state_d = CLR_IDLE;
      default:   state_d = CLR_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == CLR_CLEAR);
    done_o = (state_q == CLR_DONE);
    addr_o = addr_q;
  end
endmodule

// File: rtl/overlay_fb_arbiter.sv
// Time-slot scheduler for the single-port 1-bit overlay framebuffer.
// Each 25 MHz pixel spans 4 system-clock slots: slot 0 serves the VGA scan
// read, slots 1-3 serve the clear sequencer (priority) or the plot writer.
//   CLK100MHZ, CPU_RESETN     : clock, async active-low reset
//   disp_addr / disp_data     : VGA scan address in, registered pixel out
//   wr_valid/wr_addr/wr_data  : writer request, wr_ready accept
//   clr_start/clr_busy/clr_done : clear-screen control and status
//   oob_count                 : saturating count of dropped out-of-range writes
//   slot_phase                : current slot phase
//   mem_addr/mem_we/mem_wdata/mem_rdata : single-port RAM (1-cycle read)
module overlay_fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int DEPTH          = FB_DEPTH,
  parameter int ADDR_WIDTH     = FB_ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  CLK100MHZ,
  input  logic                  CPU_RESETN,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic                  disp_data,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_data,
  output logic                  wr_ready,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic [OOB_CNT_W-1:0]  oob_count,
  output logic [1:0]            slot_phase,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_wdata,
  input  logic                  mem_rdata
);
  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [1:0]            phase_q;
  logic                  disp_data_q;
  logic [OOB_CNT_W-1:0]  oob_q;
  logic                  write_slot, wr_fire, wr_in_range;
  logic [ADDR_WIDTH-1:0] clr_addr;

  assign write_slot  = (phase_q != SLOT_DISP);
  assign wr_ready    = write_slot & ~clr_busy;
  assign wr_fire     = wr_valid & wr_ready;
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);

  fb_clear_seq #(
    .DEPTH          (DEPTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr (
    .clk_i   (CLK100MHZ),
    .rst_ni  (CPU_RESETN),
    .start_i (clr_start),
    .step_i  (write_slot),
    .busy_o  (clr_busy),
    .done_o  (clr_done),
    .addr_o  (clr_addr)
  );

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      phase_q     <= SLOT_DISP;
      disp_data_q <= 1'b0;
      oob_q       <= '0;
    end else begin
      phase_q <= phase_q + 2'd1;
      if (phase_q == SLOT_RD_CAPTURE) disp_data_q <= mem_rdata;
      if (wr_fire && !wr_in_range && (oob_q != '1)) oob_q <= oob_q + 1'b1;
    end
  end

  // Idle slots keep presenting the scan address so the RAM port stays benign.
  always_comb begin
    mem_addr  = disp_addr;
    mem_we    = 1'b0;
    mem_wdata = 1'b0;
    if (clr_busy && write_slot) begin
      mem_addr = clr_addr;
      mem_we   = 1'b1;
    end else if (wr_fire && wr_in_range) begin
      mem_addr  = wr_addr;
      mem_we    = 1'b1;
      mem_wdata = wr_data;
    end
  end

  assign disp_data  = disp_data_q;
  assign oob_count  = oob_q;
  assign slot_phase = phase_q;
endmodule

// File: tb/tb_overlay_fb_arbiter.sv
module tb_overlay_fb_arbiter;
  localparam int DEPTH = 16;
  localparam int AW    = 19;

  typedef struct {
    logic [AW-1:0] addr;
    logic          data;
  } wr_t;

  logic          clk, rst_n;
  logic [AW-1:0] disp_addr, wr_addr, mem_addr;
  logic          disp_data, wr_valid, wr_data, wr_ready;
  logic          clr_start, clr_busy, clr_done;
  logic [7:0]    oob_count;
  logic [1:0]    slot_phase;
  logic          mem_we, mem_wdata, mem_rdata;

  int  total = 0;
  int  bad   = 0;
  int  seen  = 0;
  int  n, base;
  wr_t exp_q[$];
  bit  ram [0:63];
  logic [1:0] ph_m;

  overlay_fb_arbiter #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n),
    .disp_addr(disp_addr), .disp_data(disp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .oob_count(oob_count), .slot_phase(slot_phase),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write-through storage with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[5:0]];
  end

  // Reference slot phase.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ph_m <= 2'd0;
    else        ph_m <= ph_m + 2'd1;

  // Scoreboard: every RAM write must match the next expected write.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      seen++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_extra: got write addr=%0d data=%0b, want no write", mem_addr, mem_wdata);
      end
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        total++;
        assert (mem_addr === e.addr && mem_wdata === e.data) else begin
          bad++;
          $error("FAIL sb_write: got addr=%0d data=%0b, want addr=%0d data=%0b",
                 mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ph(input logic [1:0] p);
    for (int i = 0; i < 8; i++) begin
      if (ph_m == p) break;
      tick();
    end
  endtask

  task automatic push_clear();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('{addr: AW'(i), data: 1'b0});
  endtask

  // Counts busy cycles (bounded); optionally re-pulses clr_start at cycle restart_at.
  task automatic busy_loop(input int restart_at, output int cnt);
    cnt = 0;
    while (clr_busy && cnt < 60) begin
      total++;
      assert (wr_ready === 1'b0) else begin
        bad++;
        $error("FAIL rdy_in_clear: got %0b want 0", wr_ready);
      end
      clr_start = (cnt == restart_at);
      cnt++;
      tick();
    end
    clr_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; disp_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = 1'b0;
    clr_start = 1'b0;
    #23;
    // Reset state
    chk("rst_phase", 32'(slot_phase), 0);
    chk("rst_disp",  32'(disp_data), 0);
    chk("rst_oob",   32'(oob_count), 0);
    chk("rst_done",  32'(clr_done), 0);
    chk("rst_busy",  32'(clr_busy), 1);
    chk("rst_we",    32'(mem_we), 0);

    // Automatic clear after reset release
    push_clear();
    rst_n = 1'b1;
    busy_loop(-1, n);
    chk("auto_len",  32'(n), 22);
    chk("auto_done", 32'(clr_done), 1);
    tick();
    chk("auto_done_pulse", 32'(clr_done), 0);
    chk("auto_sb", 32'(exp_q.size()), 0);

    // Writer handshake: held from phase 0, accepted once at phase 1
    wait_ph(2'd0);
    chk("phase_align", 32'(slot_phase), 0);
    wr_valid = 1'b1; wr_addr = 19'd10; wr_data = 1'b1;
    exp_q.push_back('{addr: 19'd10, data: 1'b1});
    #1;
    chk("wr_rdy_ph0", 32'(wr_ready), 0);
    chk("wr_we_ph0",  32'(mem_we), 0);
    tick();
    chk("wr_rdy_ph1", 32'(wr_ready), 1);
    chk("wr_we_ph1",  32'(mem_we), 1);
    chk("wr_addr_ph1", 32'(mem_addr), 10);
    tick();
    wr_valid = 1'b0;

    // Display read: disp_data follows two cycles after the phase-0 sample
    wait_ph(2'd3);
    disp_addr = 19'd10;
    tick();
    chk("disp_addr_ph0", 32'(mem_addr), 10);
    chk("disp_we_ph0",   32'(mem_we), 0);
    tick();
    chk("disp_lat1", 32'(disp_data), 0);
    tick();
    chk("disp_lat2", 32'(disp_data), 1);
    tick();
    chk("disp_hold3", 32'(disp_data), 1);
    disp_addr = '0;
    tick();
    chk("disp_hold0", 32'(disp_data), 1);
    chk("idle_addr",  32'(mem_addr), 0);
    tick();
    chk("disp_hold1", 32'(disp_data), 1);
    tick();
    chk("disp_new",   32'(disp_data), 0);

    // Out-of-range writes are dropped and counted, saturating at 255
    wait_ph(2'd1);
    wr_valid = 1'b1; wr_addr = 19'd307200; wr_data = 1'b1;
    #1;
    chk("oob_rdy", 32'(wr_ready), 1);
    chk("oob_we",  32'(mem_we), 0);
    tick();
    wr_valid = 1'b0;
    chk("oob_one", 32'(oob_count), 1);
    wr_valid = 1'b1;
    repeat (400) tick();
    wr_valid = 1'b0;
    chk("oob_sat", 32'(oob_count), 255);

    // clr_start with an accepted write, then a re-pulse mid-clear and in DONE
    wait_ph(2'd1);
    wr_valid = 1'b1; wr_addr = 19'd3; wr_data = 1'b1; clr_start = 1'b1;
    exp_q.push_back('{addr: 19'd3, data: 1'b1});
    push_clear();
    #1;
    chk("sim_we",   32'(mem_we), 1);
    chk("sim_addr", 32'(mem_addr), 3);
    tick();
    wr_valid = 1'b0; clr_start = 1'b0;
    chk("sim_busy", 32'(clr_busy), 1);
    busy_loop(5, n);
    chk("clr_len_ok", 32'(n >= 21 && n <= 22), 1);
    chk("clr_done",   32'(clr_done), 1);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("done_pulse", 32'(clr_done), 0);
    chk("done_ign0",  32'(clr_busy), 0);
    tick();
    chk("done_ign1",  32'(clr_busy), 0);
    chk("clr_sb",     32'(exp_q.size()), 0);

    // Reset mid-clear at clr_addr=7, then a fresh sweep from 0
    clr_start = 1'b1;
    push_clear();
    base = seen;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (seen - base >= 7) break;
      tick();
    end
    chk("mid_count", 32'(seen - base), 7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we",   32'(mem_we), 0);
    chk("mid_rst_busy", 32'(clr_busy), 1);
    chk("mid_rst_oob",  32'(oob_count), 0);
    exp_q.delete();
    push_clear();
    repeat (3) tick();
    rst_n = 1'b1;
    busy_loop(-1, n);
    chk("rst_clr_len", 32'(n), 22);
    chk("rst_clr_done", 32'(clr_done), 1);
    tick();
    chk("final_sb", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
